// File: rtl/load_store_unit.sv
// Per-thread load/store unit: issues one LDR/STR to data memory per REQUEST and returns load data for UPDATE.
// Latency: REQUEST -> REQUESTING -> WAITING (valid up) -> DONE on the edge after ready; minimum 3 cycles.
module load_store_unit #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int         CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t           state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic                 rvld_q, rvld_d;
  logic                 wvld_q, wvld_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdat_q, wdat_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      is_read_q <= 1'b0;
      rvld_q    <= 1'b0;
      wvld_q    <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (enable) begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      rvld_q    <= rvld_d;
      wvld_q    <= wvld_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      out_q     <= out_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    rvld_d    = rvld_q;
    wvld_d    = wvld_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    out_d     = out_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write request resolves to the read.
        if (core_state == CORE_REQUEST &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_d   = REQUESTING;
          is_read_d = decoded_mem_read_enable;
        end
      end
      REQUESTING: begin
        addr_d  = rs[ADDR_BITS-1:0];
        cnt_d   = '0;
        state_d = WAITING;
        if (is_read_q) begin
          rvld_d = 1'b1;
        end else begin
          wvld_d = 1'b1;
          wdat_d = rt[DATA_BITS-1:0];
        end
      end
      WAITING: begin
        if (rvld_q && mem_read_ready) begin
          out_d   = mem_read_data;
          rvld_d  = 1'b0;
          state_d = DONE;
        end else if (wvld_q && mem_write_ready) begin
          wvld_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: the counter stops here, so it can never wrap.
          rvld_d  = 1'b0;
          wvld_d  = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (is_read_q) out_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (core_state == CORE_UPDATE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read_valid    = rvld_q;
  assign mem_read_address  = addr_q;
  assign mem_write_valid   = wvld_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdat_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so the abort path is reachable.
module tb_load_store_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] C_REQ = 3'b011, C_WAIT = 3'b100, C_EXEC = 3'b101, C_UPD = 3'b110;
  localparam logic [1:0] S_IDLE = 2'b00, S_REQ = 2'b01, S_WAIT = 2'b10, S_DONE = 2'b11;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .lsu_error                (lsu_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a request from IDLE and step to WAITING (valid raised).
  task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    core_state = C_REQ; rd_en = r; wr_en = w; rs = a; rt = d;
    tick();
    check("issue_requesting", lsu_state, S_REQ);
    core_state = C_WAIT;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("issue_waiting", lsu_state, S_WAIT);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
    rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_state", lsu_state, S_IDLE);
    check("rst_rvld", mem_read_valid, 1'b0);
    check("rst_wvld", mem_write_valid, 1'b0);
    check("rst_out", lsu_out, 8'h00);
    check("rst_err", lsu_error, 1'b0);

    // 1: load, ready two cycles after valid
    issue(1'b1, 1'b0, 8'h2A, 8'h00);
    check("ld_rvld", mem_read_valid, 1'b1);
    check("ld_addr", mem_read_address, 8'h2A);
    tick();
    check("ld_hold_vld", mem_read_valid, 1'b1);
    check("ld_hold_state", lsu_state, S_WAIT);
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 8'h00;
    check("ld_done", lsu_state, S_DONE);
    check("ld_out", lsu_out, 8'h5C);
    check("ld_vld_drop", mem_read_valid, 1'b0);
    core_state = C_EXEC;
    tick();
    check("ld_done_hold", lsu_state, S_DONE);
    core_state = C_UPD;
    tick();
    check("ld_idle", lsu_state, S_IDLE);

    // 2: store, ready immediately
    issue(1'b0, 1'b1, 8'h10, 8'hA7);
    check("st_wvld", mem_write_valid, 1'b1);
    check("st_addr", mem_write_address, 8'h10);
    check("st_data", mem_write_data, 8'hA7);
    check("st_no_rvld", mem_read_valid, 1'b0);
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    check("st_wvld_drop", mem_write_valid, 1'b0);
    check("st_done", lsu_state, S_DONE);
    check("st_out_kept", lsu_out, 8'h5C);
    core_state = C_UPD;
    tick();
    check("st_idle", lsu_state, S_IDLE);

    // 3: read and write both requested -> read only
    issue(1'b1, 1'b1, 8'h44, 8'h99);
    check("both_rvld", mem_read_valid, 1'b1);
    check("both_wvld", mem_write_valid, 1'b0);
    mem_read_ready = 1'b1; mem_read_data = 8'h33;
    tick();
    mem_read_ready = 1'b0;
    check("both_out", lsu_out, 8'h33);
    check("both_wvld_after", mem_write_valid, 1'b0);
    core_state = C_UPD;
    tick();

    // 4: load timeout after 4 WAITING cycles
    issue(1'b1, 1'b0, 8'h05, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_still_vld", mem_read_valid, 1'b1);
    end
    check("to_no_err_yet", lsu_error, 1'b0);
    tick();
    check("to_vld_drop", mem_read_valid, 1'b0);
    check("to_err", lsu_error, 1'b1);
    check("to_out", lsu_out, 8'hFF);
    check("to_done", lsu_state, S_DONE);
    core_state = C_UPD;
    tick();
    check("to_idle", lsu_state, S_IDLE);
    check("to_err_sticky", lsu_error, 1'b1);

    // 5: reset while WAITING, then a stale ready
    issue(1'b1, 1'b0, 8'h77, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_state", lsu_state, S_IDLE);
    check("rw_vld", mem_read_valid, 1'b0);
    check("rw_out", lsu_out, 8'h00);
    check("rw_err", lsu_error, 1'b0);
    core_state = C_WAIT; mem_read_ready = 1'b1; mem_read_data = 8'hEE;
    tick();
    mem_read_ready = 1'b0;
    check("stale_state", lsu_state, S_IDLE);
    check("stale_out", lsu_out, 8'h00);

    // 6: disabled thread ignores a load and ready pulses
    enable = 1'b0; core_state = C_REQ; rd_en = 1'b1; rs = 8'h3C;
    tick(); tick();
    check("dis_state", lsu_state, S_IDLE);
    check("dis_vld", mem_read_valid, 1'b0);
    mem_read_ready = 1'b1; mem_read_data = 8'hAB;
    tick();
    mem_read_ready = 1'b0;
    check("dis_out", lsu_out, 8'h00);
    check("dis_state2", lsu_state, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
